// File: rtl/duty_ramp.sv
// duty_ramp: slew-rate limiter between a requested target duty and the
// duty input of a 10-bit PWM generator. A free-running period counter
// produces an update tick; on each tick while ramping the output duty moves
// at most STEP toward the latched target. Once the target is reached, the
// block waits one more tick, then pulses done and goes back to accepting targets.
//
// Optional feature: define DUTY_RAMP_CLAMP_EN to clamp accepted targets to
// DUTY_MAX. Without the macro, targets are taken as-is and DUTY_MAX is inert.
module duty_ramp #(
  parameter int STEP     = 8,
  parameter int PERIOD   = 1024,
  parameter int DUTY_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tgt_duty,
  input  logic       tgt_vld,
  output logic       tgt_rdy,
  output logic [9:0] duty,
  output logic       tick,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0]  LAST_CNT = 10'(PERIOD - 1);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [9:0]  STEP_D   = 10'(STEP);
  localparam logic [9:0]  CEILING  = 10'(DUTY_MAX);

`ifdef DUTY_RAMP_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } state_t;

  state_t      state;
  logic [9:0]  cnt;
  logic [9:0]  tgt_q;
  logic [9:0]  accept_duty;
  logic [10:0] diff;
  logic        step_up;

  assign tick = (cnt == LAST_CNT);
  assign busy = (state != IDLE);

  // Target as it will be latched: optionally limited to the clamp ceiling.
  always_comb begin
    accept_duty = tgt_duty;
    if (CLAMP_EN && (tgt_duty > CEILING)) begin
      accept_duty = CEILING;
    end
  end

  // Distance to the target, widened by one bit so the subtraction never wraps.
  always_comb begin
    step_up = (tgt_q > duty);
    if (step_up) begin
      diff = {1'b0, tgt_q} - {1'b0, duty};
    end else begin
      diff = {1'b0, duty} - {1'b0, tgt_q};
    end
  end

  // Period counter free-runs in every state so ticks stay aligned with the PWM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

  // Handshake, ramp stepping and completion sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      duty    <= '0;
      tgt_q   <= '0;
      tgt_rdy <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_vld && tgt_rdy) begin
            tgt_q   <= accept_duty;
            tgt_rdy <= 1'b0;
            state   <= (accept_duty != duty) ? RAMP : SETTLE;
          end else begin
            tgt_rdy <= 1'b1;
          end
        end
        RAMP: begin
          tgt_rdy <= 1'b0;
          if (tick) begin
            if (diff <= STEP_W) begin
              duty  <= tgt_q;
              state <= SETTLE;
            end else if (step_up) begin
              duty <= duty + STEP_D;
            end else begin
              duty <= duty - STEP_D;
            end
          end
        end
        SETTLE: begin
          tgt_rdy <= 1'b0;
          if (tick) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          tgt_rdy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: self-checking bench for duty_ramp. A transaction-level model
// turns each accepted target into the list of duty values it must pass
// through, one per tick, and a per-cycle compare process holds the DUT to it.
// Directed sequences with literal expectations pin the model, followed by a
// randomized run of targets.
module tb_duty_ramp;

  localparam int STEP_P     = 8;
  localparam int PERIOD_P   = 8;
  localparam int DUTY_MAX_P = 900;

  logic       clk;
  logic       rst_n;
  logic [9:0] tgt_duty;
  logic       tgt_vld;
  logic       tgt_rdy;
  logic [9:0] duty;
  logic       tick;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  bit check_en;

  // Model state.
  int m_cnt;
  int m_duty;
  int m_steps[$];
  bit m_busy;
  bit m_done;
  bit m_rdy;
  bit m_xfer;
  bit m_tick_now;
  int m_target;
  int m_v;

  // Trace of DUT duty sampled after each tick, filled by collectTrace.
  int trace[$];
  bit got_done;

  duty_ramp #(
    .STEP    (STEP_P),
    .PERIOD  (PERIOD_P),
    .DUTY_MAX(DUTY_MAX_P)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgt_duty(tgt_duty),
    .tgt_vld (tgt_vld),
    .tgt_rdy (tgt_rdy),
    .duty    (duty),
    .tick    (tick),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int traceAt(input int i);
    return (i < trace.size()) ? trace[i] : -1;
  endfunction

  // Transaction model: an accepted target becomes a queue of per-tick duty values;
  // an empty queue while busy means the next tick completes the target.
  always @(posedge clk) begin
    m_xfer = 1'b0;
    if (!rst_n) begin
      m_cnt  = 0;
      m_duty = 0;
      m_steps.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_rdy  = 1'b0;
    end else begin
      m_tick_now = (m_cnt == PERIOD_P - 1);
      m_cnt      = (m_cnt + 1) % PERIOD_P;
      m_done     = 1'b0;
      if (m_busy) begin
        if (m_tick_now) begin
          if (m_steps.size() > 0) begin
            m_duty = m_steps.pop_front();
          end else begin
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end else if (m_rdy && tgt_vld) begin
`ifdef DUTY_RAMP_CLAMP_EN
        m_target = (int'(tgt_duty) > DUTY_MAX_P) ? DUTY_MAX_P : int'(tgt_duty);
`else
        m_target = int'(tgt_duty);
`endif
        m_steps.delete();
        m_v = m_duty;
        while (m_v != m_target) begin
          if (((m_target > m_v) ? (m_target - m_v) : (m_v - m_target)) <= STEP_P) begin
            m_v = m_target;
          end else if (m_target > m_v) begin
            m_v = m_v + STEP_P;
          end else begin
            m_v = m_v - STEP_P;
          end
          m_steps.push_back(m_v);
        end
        m_busy = 1'b1;
        m_rdy  = 1'b0;
        m_xfer = 1'b1;
      end else begin
        m_rdy = 1'b1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("duty", int'(duty), m_duty);
      checkOutput("tick", int'(tick), (m_cnt == PERIOD_P - 1) ? 1 : 0);
      checkOutput("tgt_rdy", int'(tgt_rdy), int'(m_rdy));
      checkOutput("busy", int'(busy), int'(m_busy));
      checkOutput("done", int'(done), int'(m_done));
    end
  end

  // Runaway guard.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Present a target and hold it until the model records the transfer.
  task automatic applyStimulus(input int value);
    bit got;
    got = 1'b0;
    @(negedge clk);
    tgt_duty = 10'(value);
    tgt_vld  = 1'b1;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk);
      #1;
      if (m_xfer) got = 1'b1;
    end
    if (!got) checkOutput("xfer_timeout", 0, 1);
    @(negedge clk);
    tgt_vld  = 1'b0;
    tgt_duty = 10'($urandom_range(0, 1023));
  endtask

  // Record DUT duty after every tick until done is seen.
  task automatic collectTrace();
    trace.delete();
    got_done = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      if (tick) begin
        @(negedge clk);
        trace.push_back(int'(duty));
        if (done) got_done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got_done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (tgt_rdy) ok = 1'b1;
    end
    if (!ok) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed sequences, then randomized targets.
  initial begin
    int  tv;
    int  edges;
    bit  seen_tick;
    bit  done_seen;
    bit  ok;
    int  exp_last;
    int  exp_prev;
    int  exp_n;

    checks   = 0;
    failures = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    tgt_vld  = 1'b0;
    tgt_duty = '0;

    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    checkOutput("reset_duty", int'(duty), 0);
    checkOutput("reset_rdy", int'(tgt_rdy), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_tick", int'(tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rdy_first_clock", int'(tgt_rdy), 1);

    // Target equal to current duty settles without moving.
    applyStimulus(0);
    checkOutput("eq_busy", int'(busy), 1);
    collectTrace();
    checkOutput("eq_ticks", trace.size(), 1);
    checkOutput("eq_duty", traceAt(0), 0);

    // Ramp 0 -> 100.
    waitIdle();
    applyStimulus(100);
    checkOutput("up_plan_len", m_steps.size(), 13);
    collectTrace();
    checkOutput("up_ticks", trace.size(), 14);
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("up_tick%0d", k), traceAt(k - 1), 8 * k);
    end
    checkOutput("up_tick13", traceAt(12), 100);
    checkOutput("up_done_duty", traceAt(13), 100);
    checkOutput("up_busy_at_done", int'(busy), 0);
    checkOutput("up_rdy_at_done", int'(tgt_rdy), 0);
    checkOutput("up_model_final", m_duty, 100);
    @(negedge clk);
    checkOutput("up_rdy_after_done", int'(tgt_rdy), 1);

    // Ramp 100 -> 20.
    applyStimulus(20);
    collectTrace();
    checkOutput("down_ticks", trace.size(), 11);
    for (int k = 1; k <= 9; k++) begin
      checkOutput($sformatf("down_tick%0d", k), traceAt(k - 1), 100 - 8 * k);
    end
    checkOutput("down_tick10", traceAt(9), 20);

    // A target held during a ramp is ignored until the block is ready again.
    waitIdle();
    applyStimulus(200);
    tgt_duty = 10'd300;
    tgt_vld  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) checkOutput("hold_done_timeout", 0, 1);
    checkOutput("hold_duty_at_done", int'(duty), 200);
    checkOutput("hold_rdy_at_done", int'(tgt_rdy), 0);
    @(negedge clk);
    checkOutput("hold_rdy_next", int'(tgt_rdy), 1);
    @(negedge clk);
    checkOutput("hold_xfer_busy", int'(busy), 1);
    tgt_vld = 1'b0;
    collectTrace();
    checkOutput("hold_ticks", trace.size(), 14);
    checkOutput("hold_final", traceAt(13), 300);

    // Full-scale request from zero: clamped or unclamped end point.
    pulseReset();
`ifdef DUTY_RAMP_CLAMP_EN
    exp_last = 900;
    exp_prev = 896;
    exp_n    = 114;
`else
    exp_last = 1023;
    exp_prev = 1016;
    exp_n    = 129;
`endif
    applyStimulus(1023);
    collectTrace();
    checkOutput("full_ticks", trace.size(), exp_n);
    checkOutput("full_prev", traceAt(exp_n - 3), exp_prev);
    checkOutput("full_last", traceAt(exp_n - 2), exp_last);

    // Reset in the middle of a ramp.
    pulseReset();
    applyStimulus(100);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (duty == 10'd48) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) checkOutput("mid_reach48_timeout", 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_duty", int'(duty), 0);
    checkOutput("mid_rst_tick", int'(tick), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    checkOutput("mid_rst_rdy", int'(tgt_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    edges     = 0;
    seen_tick = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 4 * PERIOD_P; c++) begin
      @(posedge clk);
      #1;
      if (!seen_tick) edges++;
      if (tick) seen_tick = 1'b1;
      if (done) done_seen = 1'b1;
    end
    checkOutput("mid_first_tick_edges", edges, PERIOD_P - 1);
    checkOutput("mid_no_done", int'(done_seen), 0);

    // Randomized targets, sometimes queued while the previous one still ramps.
    for (int i = 0; i < 12; i++) begin
      tv = ($urandom_range(0, 3) == 0) ? m_duty : int'($urandom_range(0, 1023));
      applyStimulus(tv);
      if ($urandom_range(0, 1) == 1) begin
        waitIdle();
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    waitIdle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
